// File: rtl/vc_ctrl_pkg.sv
// vc_ctrl_pkg: state encoding and shared constants for the VC arbiter
package vc_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } vc_state_e;
  localparam int WEIGHT_DEF = 4;
  localparam int PIPE_DEPTH = 2;
endpackage

// File: rtl/vc_wrr_sel.sv
// vc_wrr_sel: weighted-priority VC0/VC1 pop selector; VC0 wins up to WEIGHT times in a row while VC1 waits
module vc_wrr_sel
  import vc_ctrl_pkg::*;
#(
  parameter int WEIGHT = WEIGHT_DEF
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       en,
  input  logic       vc0_empty,
  input  logic       vc1_empty,
  output logic [1:0] pop
);
  localparam logic [3:0] W = 4'(WEIGHT);
  logic [3:0] cnt_q, cnt_d;
  logic pick0;
  always_comb begin
    pick0 = !vc0_empty && (vc1_empty || cnt_q < W);
    pop = en ? {!pick0 && !vc1_empty, pick0} : 2'b00;
    cnt_d = (vc1_empty || pop[1]) ? 4'd0 : pop[0] ? cnt_q + 4'd1 : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= !reset_L ? 4'd0 : cnt_d;
endmodule

// File: rtl/vc_arbiter_fsm.sv
// vc_arbiter_fsm: init/threshold FSM with weighted two-VC read arbiter and registered merged output stream
module vc_arbiter_fsm
  import vc_ctrl_pkg::*;
#(
  parameter int BW     = 6,
  parameter int LEN16  = 16,
  parameter int WEIGHT = WEIGHT_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic [LEN16-1:0] umbral_low_in,
  input  logic [LEN16-1:0] umbral_high_in,
  input  logic             VC0_empty,
  input  logic             VC1_empty,
  input  logic             VC0_error_output,
  input  logic             VC1_error_output,
  input  logic [BW-1:0]    VC0_data_out,
  input  logic [BW-1:0]    VC1_data_out,
  input  logic             pause,
  output logic             VC0_rd,
  output logic             VC1_rd,
  output logic [LEN16-1:0] UmbralV0_LOW_cond,
  output logic [LEN16-1:0] UmbralV0_HIGH_cond,
  output logic [LEN16-1:0] UmbralV1_LOW_cond,
  output logic [LEN16-1:0] UmbralV1_HIGH_cond,
  output logic [BW-1:0]    data_out,
  output logic             valid_out,
  output logic [2:0]       state,
  output logic             error_out
);
  vc_state_e state_q, state_d;
  logic [LEN16-1:0] low_q, low_d, high_q, high_d;
  logic [BW-1:0] dat_q, dat_d;
  logic rd0_q, rd1_q, p1_vld_q, p1_sel_q, vld_q, vld_d, err, en;
  logic [1:0] pop;
  logic [PIPE_DEPTH-1:0] pend;
  assign err = VC0_error_output | VC1_error_output;
  assign pend = {p1_vld_q, rd0_q | rd1_q};
  always_comb begin
    state_d = (err || state_q == ST_ERROR) ? ST_ERROR :
              state_q == ST_RESET ? ST_INIT :
              state_q == ST_INIT ? (init ? ST_INIT : ST_IDLE) :
              state_q == ST_IDLE ? ((!VC0_empty || !VC1_empty) ? ST_ACTIVE : init ? ST_INIT : ST_IDLE) :
              (VC0_empty && VC1_empty && !(|pend)) ? ST_IDLE : init ? ST_INIT : ST_ACTIVE;
    low_d = state_q == ST_INIT ? umbral_low_in : low_q;
    high_d = state_q == ST_INIT ? umbral_high_in : high_q;
    en = state_d == ST_ACTIVE && !pause;
    vld_d = p1_vld_q && state_d != ST_ERROR;
    dat_d = vld_d ? (p1_sel_q ? VC1_data_out : VC0_data_out) : dat_q;
  end
  vc_wrr_sel #(.WEIGHT(WEIGHT)) u_sel (
    .clk       (clk),
    .reset_L   (reset_L),
    .en        (en),
    .vc0_empty (VC0_empty),
    .vc1_empty (VC1_empty),
    .pop       (pop)
  );
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q  <= ST_RESET;
      low_q    <= '0;
      high_q   <= '0;
      rd0_q    <= 1'b0;
      rd1_q    <= 1'b0;
      p1_vld_q <= 1'b0;
      p1_sel_q <= 1'b0;
      vld_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      low_q    <= low_d;
      high_q   <= high_d;
      rd0_q    <= pop[0];
      rd1_q    <= pop[1];
      p1_vld_q <= rd0_q | rd1_q;
      p1_sel_q <= rd1_q;
      vld_q    <= vld_d;
      dat_q    <= dat_d;
    end
  end
  assign VC0_rd = rd0_q;
  assign VC1_rd = rd1_q;
  assign UmbralV0_LOW_cond = low_q;
  assign UmbralV0_HIGH_cond = high_q;
  assign UmbralV1_LOW_cond = low_q;
  assign UmbralV1_HIGH_cond = high_q;
  assign data_out = dat_q;
  assign valid_out = vld_q;
  assign state = state_q;
  assign error_out = state_q == ST_ERROR;
endmodule

// File: tb/tb_vc_arbiter_fsm.sv
// tb_vc_arbiter_fsm: randomized cycle-accurate check of vc_arbiter_fsm against a queue-based reference model
module tb_vc_arbiter_fsm;
  import vc_ctrl_pkg::*;
  localparam int BW = 6;
  localparam int W = 4;
  logic clk = 1'b0, reset_L = 1'b0, init = 1'b0, pause = 1'b0;
  logic VC0_error_output = 1'b0, VC1_error_output = 1'b0;
  logic VC0_empty = 1'b1, VC1_empty = 1'b1;
  logic [15:0] umbral_low_in = '0, umbral_high_in = '0;
  logic [BW-1:0] VC0_data_out = '0, VC1_data_out = '0;
  logic VC0_rd, VC1_rd, valid_out, error_out;
  logic [15:0] UmbralV0_LOW_cond, UmbralV0_HIGH_cond, UmbralV1_LOW_cond, UmbralV1_HIGH_cond;
  logic [BW-1:0] data_out;
  logic [2:0] state;
  int n_chk = 0, n_pass = 0;
  logic [BW-1:0] f0[$], f1[$], m0[$], m1[$];
  logic [BW-1:0] nxt0 = '0, nxt1 = '0;
  vc_state_e ms = ST_RESET;
  logic [15:0] m_low = '0, m_high = '0;
  logic m_rd0 = 1'b0, m_rd1 = 1'b0, m_p1v = 1'b0, m_v = 1'b0;
  logic [BW-1:0] m_rdw = '0, m_p1w = '0, m_d = '0;
  int streak = 0;

  initial forever #5 clk = ~clk;

  vc_arbiter_fsm dut (
    .clk                (clk),
    .reset_L            (reset_L),
    .init               (init),
    .umbral_low_in      (umbral_low_in),
    .umbral_high_in     (umbral_high_in),
    .VC0_empty          (VC0_empty),
    .VC1_empty          (VC1_empty),
    .VC0_error_output   (VC0_error_output),
    .VC1_error_output   (VC1_error_output),
    .VC0_data_out       (VC0_data_out),
    .VC1_data_out       (VC1_data_out),
    .pause              (pause),
    .VC0_rd             (VC0_rd),
    .VC1_rd             (VC1_rd),
    .UmbralV0_LOW_cond  (UmbralV0_LOW_cond),
    .UmbralV0_HIGH_cond (UmbralV0_HIGH_cond),
    .UmbralV1_LOW_cond  (UmbralV1_LOW_cond),
    .UmbralV1_HIGH_cond (UmbralV1_HIGH_cond),
    .data_out           (data_out),
    .valid_out          (valid_out),
    .state              (state),
    .error_out          (error_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic step();
    bit e0, e1, busy;
    vc_state_e nx;
    if (!reset_L) begin
      ms = ST_RESET;
      m_low = '0;
      m_high = '0;
      m_rd0 = 1'b0;
      m_rd1 = 1'b0;
      m_p1v = 1'b0;
      m_v = 1'b0;
      m_d = '0;
      streak = 0;
      return;
    end
    e0 = m0.size() == 0;
    e1 = m1.size() == 0;
    busy = m_rd0 || m_rd1 || m_p1v;
    case (ms)
      ST_RESET:  nx = ST_INIT;
      ST_INIT:   nx = init ? ST_INIT : ST_IDLE;
      ST_IDLE:   nx = (!e0 || !e1) ? ST_ACTIVE : (init ? ST_INIT : ST_IDLE);
      ST_ACTIVE: nx = (e0 && e1 && !busy) ? ST_IDLE : (init ? ST_INIT : ST_ACTIVE);
      default:   nx = ST_ERROR;
    endcase
    if (VC0_error_output || VC1_error_output) nx = ST_ERROR;
    if (ms == ST_INIT) begin
      m_low = umbral_low_in;
      m_high = umbral_high_in;
    end
    m_v = m_p1v && nx != ST_ERROR;
    if (m_v) m_d = m_p1w;
    m_p1v = m_rd0 || m_rd1;
    m_p1w = m_rdw;
    m_rd0 = 1'b0;
    m_rd1 = 1'b0;
    if (nx == ST_ACTIVE && !pause) begin
      if (!e0 && (e1 || streak < W)) begin
        m_rd0 = 1'b1;
        m_rdw = m0.pop_front();
        streak++;
      end else if (!e1) begin
        m_rd1 = 1'b1;
        m_rdw = m1.pop_front();
        streak = 0;
      end
    end
    if (e1) streak = 0;
    ms = nx;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      step();
      @(negedge clk);
      chk("state", 32'(state), 32'(ms));
      chk("vc0_rd", 32'(VC0_rd), 32'(m_rd0));
      chk("vc1_rd", 32'(VC1_rd), 32'(m_rd1));
      chk("valid_out", 32'(valid_out), 32'(m_v));
      if (m_v || ms == ST_RESET) chk("data_out", 32'(data_out), 32'(m_d));
      chk("v0_low", 32'(UmbralV0_LOW_cond), 32'(m_low));
      chk("v0_high", 32'(UmbralV0_HIGH_cond), 32'(m_high));
      chk("v1_low", 32'(UmbralV1_LOW_cond), 32'(m_low));
      chk("v1_high", 32'(UmbralV1_HIGH_cond), 32'(m_high));
      chk("error_out", 32'(error_out), 32'(ms == ST_ERROR));
      VC0_data_out = nxt0;
      VC1_data_out = nxt1;
      if (VC0_rd) begin
        chk("vc0_rd_not_empty", 32'(f0.size() != 0), 32'd1);
        if (f0.size() != 0) nxt0 = f0.pop_front();
      end
      if (VC1_rd) begin
        chk("vc1_rd_not_empty", 32'(f1.size() != 0), 32'd1);
        if (f1.size() != 0) nxt1 = f1.pop_front();
      end
      VC0_empty = f0.size() == 0;
      VC1_empty = f1.size() == 0;
    end
  endtask

  task automatic push(input int vc, input logic [BW-1:0] w);
    if (vc == 0) begin
      f0.push_back(w);
      m0.push_back(w);
    end else begin
      f1.push_back(w);
      m1.push_back(w);
    end
    VC0_empty = f0.size() == 0;
    VC1_empty = f1.size() == 0;
  endtask

  task automatic load(input int a, input int b);
    repeat (a) push(0, BW'($urandom_range(0, 63)));
    repeat (b) push(1, BW'($urandom_range(0, 63)));
  endtask

  initial begin
    cyc(3);
    reset_L = 1'b1;
    init = 1'b1;
    umbral_low_in = 16'd2;
    umbral_high_in = 16'd14;
    cyc(2);
    init = 1'b0;
    cyc(2);
    chk("init_reaches_idle", 32'(state), 32'(ST_IDLE));
    push(0, 6'h11);
    push(0, 6'h22);
    push(0, 6'h33);
    cyc(10);
    chk("drain_back_idle", 32'(state), 32'(ST_IDLE));
    load(10, 10);
    cyc(30);
    load(8, 8);
    cyc(3);
    pause = 1'b1;
    cyc(5);
    pause = 1'b0;
    cyc(25);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) load($urandom_range(0, 4), $urandom_range(0, 4));
      pause = $urandom_range(0, 3) == 0;
      cyc(1);
    end
    pause = 1'b0;
    cyc(40);
    load(5, 5);
    cyc(3);
    VC1_error_output = 1'b1;
    cyc(1);
    VC1_error_output = 1'b0;
    cyc(6);
    chk("error_sticky", 32'(error_out), 32'd1);
    reset_L = 1'b0;
    cyc(2);
    reset_L = 1'b1;
    init = 1'b1;
    umbral_low_in = 16'h0005;
    umbral_high_in = 16'h0123;
    cyc(2);
    init = 1'b0;
    cyc(30);
    load(6, 0);
    cyc(3);
    reset_L = 1'b0;
    cyc(1);
    chk("reset_kills_valid", 32'(valid_out), 32'd0);
    reset_L = 1'b1;
    init = 1'b1;
    cyc(1);
    init = 1'b0;
    cyc(25);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
